// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: writeback has priority, MDU results are
// buffered in a small FIFO, and a busy scoreboard stalls decode on pending MDU rds.
module rf_write_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_d,
  output logic        stall_d,
  output logic        bubble_req,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [3:0]    LIMIT      = 4'(STARVE_LIMIT);

  logic [36:0]   fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic [3:0]    starve_r;
  logic [3:0]    starve_next_s;
  logic [31:0]   busy_r;
  logic [31:0]   busy_next_s;
  logic          fifo_empty_s;
  logic          push_s;
  logic          pop_s;
  logic [4:0]    head_rd_s;
  logic [31:0]   head_data_s;
  logic          rf_we_next_s;
  logic [4:0]    rf_waddr_next_s;
  logic [31:0]   rf_wdata_next_s;

  assign fifo_empty_s = (count_r == {CW{1'b0}});
  assign mdu_ready    = (count_r != FULL_COUNT);
  assign push_s       = mdu_valid & mdu_ready;
  // Occupancy is registered, so an entry pushed into an empty FIFO pops no earlier than next cycle.
  assign pop_s        = ~wb_valid & ~fifo_empty_s;
  assign {head_rd_s, head_data_s} = fifo_mem_r[rd_ptr_r];
  assign stall_d      = busy_r[rs1_d] | busy_r[rs2_d] | busy_r[rd_d];

  // FIFO occupancy update
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Starvation counter and scoreboard next state; a same-cycle set overrides the clear
  always_comb begin
    starve_next_s = starve_r;
    if (pop_s | fifo_empty_s) begin
      starve_next_s = 4'd0;
    end else if (wb_valid && (starve_r != LIMIT)) begin
      starve_next_s = starve_r + 4'd1;
    end else begin
      starve_next_s = starve_r;
    end
    busy_next_s = busy_r;
    if (pop_s && (head_rd_s != 5'd0)) begin
      busy_next_s[head_rd_s] = 1'b0;
    end else begin
      busy_next_s = busy_r;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_next_s[issue_rd] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end
  end

  // Write-port source selection
  always_comb begin
    rf_we_next_s    = 1'b0;
    rf_waddr_next_s = rf_waddr;
    rf_wdata_next_s = rf_wdata;
    if (wb_valid) begin
      rf_we_next_s    = (wb_rd != 5'd0);
      rf_waddr_next_s = wb_rd;
      rf_wdata_next_s = wb_data;
    end else if (pop_s) begin
      rf_we_next_s    = (head_rd_s != 5'd0);
      rf_waddr_next_s = head_rd_s;
      rf_wdata_next_s = head_data_s;
    end else begin
      rf_we_next_s    = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= 37'd0;
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      starve_r   <= 4'd0;
      busy_r     <= 32'd0;
      bubble_req <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= 5'd0;
      rf_wdata   <= 32'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {mdu_rd, mdu_data};
        wr_ptr_r             <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r    <= count_next_s;
      starve_r   <= starve_next_s;
      busy_r     <= busy_next_s;
      bubble_req <= (starve_next_s == LIMIT);
      rf_we      <= rf_we_next_s;
      rf_waddr   <= rf_waddr_next_s;
      rf_wdata   <= rf_wdata_next_s;
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: queue-based reference model,
// directed scenarios pinned with literal expectations, then random traffic.
module tb_rf_write_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0, mdu_valid = 1'b0, issue_valid = 1'b0;
  logic [4:0]  wb_rd = 5'd0, mdu_rd = 5'd0, issue_rd = 5'd0;
  logic [31:0] wb_data = 32'd0, mdu_data = 32'd0;
  logic [4:0]  rs1_d = 5'd0, rs2_d = 5'd0, rd_d = 5'd0;
  logic        mdu_ready, stall_d, bubble_req, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  rf_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .stall_d(stall_d),
    .bubble_req(bubble_req),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  bit          busy[32];
  int          starve;
  bit          m_we, m_bub, accepted;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    foreach (busy[i]) busy[i] = 1'b0;
    starve = 0; m_we = 1'b0; m_bub = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
  endtask

  task automatic idle();
    wb_valid = 1'b0; mdu_valid = 1'b0; issue_valid = 1'b0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    bit   rdy, was_empty, popd;
    ent_t e;
    #1;
    rdy       = (q.size() < DEPTH);
    was_empty = (q.size() == 0);
    chk("mdu_ready", 32'(mdu_ready), 32'(rdy));
    chk("stall_d", 32'(stall_d), 32'(busy[rs1_d] | busy[rs2_d] | busy[rd_d]));
    popd = 1'b0;
    if (wb_valid) begin
      m_we = (wb_rd != 5'd0); m_waddr = wb_rd; m_wdata = wb_data;
    end else if (!was_empty) begin
      e = q.pop_front(); popd = 1'b1;
      m_we = (e.rd != 5'd0); m_waddr = e.rd; m_wdata = e.data;
      busy[e.rd] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (popd || was_empty) starve = 0;
    else if (wb_valid && starve < LIMIT) starve++;
    m_bub = (starve == LIMIT);
    accepted = mdu_valid && rdy;
    if (accepted) begin
      e.rd = mdu_rd; e.data = mdu_data;
      q.push_back(e);
    end
    if (issue_valid && issue_rd != 5'd0) busy[issue_rd] = 1'b1;
    @(posedge clk); #1;
    chk("rf_we", 32'(rf_we), 32'(m_we));
    chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("bubble_req", 32'(bubble_req), 32'(m_bub));
  endtask

  initial begin
    bit          pend;
    logic [4:0]  prd;
    logic [31:0] pdata;

    // Reset state
    model_reset();
    rs1_d = 5'd5; rs2_d = 5'd5; rd_d = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_bubble", 32'(bubble_req), 32'd0);
    chk("rst_ready", 32'(mdu_ready), 32'd1);
    chk("rst_stall", 32'(stall_d), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Writeback only
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234;
    step();
    chk("wb_we", 32'(rf_we), 32'd1);
    chk("wb_addr", 32'(rf_waddr), 32'd7);
    chk("wb_data", rf_wdata, 32'h1234);
    wb_rd = 5'd0; wb_data = 32'h55;
    step();
    chk("wb_x0_we", 32'(rf_we), 32'd0);

    // MDU path and scoreboard
    idle(); issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    issue_valid = 1'b0; rs1_d = 5'd9; rs2_d = 5'd0; rd_d = 5'd0;
    #1 chk("issue_stall", 32'(stall_d), 32'd1);
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'hBEEF;
    step();
    chk("push_no_write", 32'(rf_we), 32'd0);
    mdu_valid = 1'b0;
    step();
    chk("mdu_we", 32'(rf_we), 32'd1);
    chk("mdu_addr", 32'(rf_waddr), 32'd9);
    chk("mdu_data", rf_wdata, 32'hBEEF);
    chk("mdu_stall_drop", 32'(stall_d), 32'd0);

    // Contention and starvation
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h1;
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'h33;
    step();
    mdu_valid = 1'b0;
    repeat (3) step();
    chk("starve_not_yet", 32'(bubble_req), 32'd0);
    step();
    chk("starve_bubble", 32'(bubble_req), 32'd1);
    repeat (2) step();
    chk("bubble_held", 32'(bubble_req), 32'd1);
    chk("wb_still_wins", 32'(rf_waddr), 32'd1);
    wb_valid = 1'b0;
    step();
    chk("starve_pop_addr", 32'(rf_waddr), 32'd3);
    chk("starve_pop_data", rf_wdata, 32'h33);
    chk("bubble_clear", 32'(bubble_req), 32'd0);

    // Backpressure and FIFO order
    wb_valid = 1'b1; wb_rd = 5'd2;
    mdu_valid = 1'b1; mdu_rd = 5'd20; mdu_data = 32'hA0;
    step();
    mdu_rd = 5'd21; mdu_data = 32'hA1;
    step();
    chk("full_ready", 32'(mdu_ready), 32'd0);
    mdu_rd = 5'd22; mdu_data = 32'hA2;
    step();
    chk("third_rejected", 32'(accepted), 32'd0);
    wb_valid = 1'b0;
    step();
    chk("order0", 32'(rf_waddr), 32'd20);
    step();
    chk("order1", 32'(rf_waddr), 32'd21);
    mdu_valid = 1'b0;
    step();
    chk("order2", 32'(rf_waddr), 32'd22);
    chk("order2_data", rf_wdata, 32'hA2);

    // Set and clear of the same register in one cycle
    idle(); issue_valid = 1'b1; issue_rd = 5'd12;
    step();
    issue_valid = 1'b0; mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'hC0DE;
    step();
    mdu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd12;
    step();
    issue_valid = 1'b0; rs1_d = 5'd12;
    #1 chk("set_wins", 32'(stall_d), 32'd1);
    chk("set_wins_addr", 32'(rf_waddr), 32'd12);

    // Reset with the FIFO full
    wb_valid = 1'b1; wb_rd = 5'd4;
    mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'h44;
    issue_valid = 1'b1; issue_rd = 5'd6;
    step();
    issue_valid = 1'b0; mdu_rd = 5'd5;
    step();
    chk("pre_reset_full", 32'(mdu_ready), 32'd0);
    idle(); rs1_d = 5'd6;
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(rf_we), 32'd0);
    chk("mid_rst_ready", 32'(mdu_ready), 32'd1);
    chk("mid_rst_stall", 32'(stall_d), 32'd0);
    chk("mid_rst_bubble", 32'(bubble_req), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_no_write", 32'(rf_we), 32'd0);

    // Randomized traffic; the MDU holds an offered result until accepted
    pend = 1'b0; prd = 5'd0; pdata = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      wb_valid = ($urandom_range(0, 9) < 6);
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1; prd = 5'($urandom_range(0, 7)); pdata = $urandom;
      end
      mdu_valid   = pend; mdu_rd = prd; mdu_data = pdata;
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd    = 5'($urandom_range(0, 7));
      rs1_d = 5'($urandom_range(0, 7));
      rs2_d = 5'($urandom_range(0, 7));
      rd_d  = 5'($urandom_range(0, 7));
      step();
      if (accepted) pend = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
